// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } ser_state_t;

  // Level driven on the serial line between frames.
  localparam logic IDLE_BIT = 1'b0;

  // The bit counter must be able to hold the value WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// Single-entry holding register that sits in front of the shifter.
// The word is captured on accept and released on consume. A simultaneous
// accept refills the register, so hold_full stays set.
module ser_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             consume,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  // Next-state logic: accept wins over consume.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end else if (consume) begin
      hold_full_d = 1'b0;
    end
  end

  // Holding register state with async active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign hold_data = hold_q;
  assign hold_full = hold_full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the pattern detector.
// Words arrive over valid/ready and leave one bit per clock on x_out,
// qualified by x_valid. A holding register permits gapless frames.
// Optional: define SER_PARITY_EN to append an even-parity bit to each frame.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             last_data_bit;
  logic             last_cycle;
  logic             load_now;
  logic             accept;
  logic [IDX_W-1:0] bit_idx;

  ser_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .consume   (load_now),
    .in_data   (in_data),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  // Frame-end detection and handshake, from registered state only.
  assign last_data_bit = (state_q == S_SHIFT) && (bit_cnt_q == CNT_W'(WIDTH - 1));
`ifdef SER_PARITY_EN
  assign last_cycle = (state_q == S_PAR);
`else
  assign last_cycle = last_data_bit;
`endif
  assign load_now = hold_full && ((state_q == S_IDLE) || last_cycle);
  assign in_ready = !hold_full || load_now;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE) || hold_full;

  // Bit position of the current frame bit inside shift_q.
  always_comb begin
    if (MSB_FIRST) begin
      bit_idx = IDX_W'(CNT_W'(WIDTH - 1) - bit_cnt_q);
    end else begin
      bit_idx = IDX_W'(bit_cnt_q);
    end
  end

  // Shifter FSM: next state, counter, shift register and serial outputs.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    x_valid     = 1'b0;
    x_out       = IDLE_BIT;
    frame_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_SHIFT: begin
        x_valid     = 1'b1;
        x_out       = shift_q[bit_idx];
        frame_start = (bit_cnt_q == '0);
        if (last_data_bit) begin
`ifdef SER_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_IDLE;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
`ifdef SER_PARITY_EN
      S_PAR: begin
        x_valid = 1'b1;
        x_out   = ^shift_q;
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A waiting word starts a new frame straight away, including reloads.
    if (load_now) begin
      state_d   = S_SHIFT;
      shift_d   = hold_data;
      bit_cnt_d = '0;
    end
  end

  // Shifter state registers with async active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule
